conv_encoder: RTL and testbench

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder_if.sv | 22 ++
 rtl/conv_encoder.sv | 166 ++++++++++++++++
 tb/tb_conv_encoder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_encoder_if.sv
// Bit-stream interface of the convolutional encoder: the information-bit handshake
// on the input side and the registered symbol/framing strobes on the output side.
interface conv_encoder_if;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_sym;
   logic       frame_start;
   logic       frame_end;
   logic       underrun;

   modport slave (
      input  in_valid, in_bit,
      output in_ready, out_valid, out_sym, frame_start, frame_end, underrun
   );

   modport master (
      output in_valid, in_bit,
      input  in_ready, out_valid, out_sym, frame_start, frame_end, underrun
   );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 (171/133 octal) convolutional encoder with an input FIFO, paced by a
// synchronized bit_clk, framing FRAME_LEN data bits followed by six zero tail bits.
module conv_encoder #(
   parameter int FRAME_LEN  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input logic           clk,
   input logic           rst,
   input logic           bit_clk,
   conv_encoder_if.slave bus
);

   localparam int             AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0]    LAST_BIT  = 16'(FRAME_LEN);

   typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

   function automatic logic [1:0] encode(input logic u, input logic [5:0] s);
      return {u ^ s[0] ^ s[1] ^ s[2] ^ s[5], u ^ s[1] ^ s[2] ^ s[4] ^ s[5]};
   endfunction

   logic          sync1_q, sync2_q, sync_prev_q;
   logic          rdy_q;
   logic          tick;
   logic          mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push, pop, empty, full, head;
   state_t        state_q, state_d;
   logic [5:0]    shift_q, shift_d;
   logic [15:0]   bit_cnt_q, bit_cnt_d;
   logic [2:0]    tail_cnt_q, tail_cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [1:0]    out_sym_q, out_sym_d;
   logic          frame_start_q, frame_start_d;
   logic          frame_end_q, frame_end_d;
   logic          underrun_q, underrun_d;

   // Synchronizer flops reset high so a bit_clk held high through reset gives no tick.
   assign tick  = sync2_q & ~sync_prev_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_CNT);
   assign head  = mem_q[rd_ptr_q];
   assign push  = bus.in_valid & bus.in_ready;

   assign bus.in_ready    = rdy_q & ~full;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_sym     = out_sym_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_end   = frame_end_q;
   assign bus.underrun    = underrun_q;

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      tail_cnt_d    = tail_cnt_q;
      pop           = 1'b0;
      out_valid_d   = 1'b0;
      out_sym_d     = out_sym_q;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      underrun_d    = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  pop           = 1'b1;
                  out_valid_d   = 1'b1;
                  out_sym_d     = encode(head, shift_q);
                  shift_d       = {shift_q[4:0], head};
                  bit_cnt_d     = 16'd1;
                  frame_start_d = 1'b1;
                  tail_cnt_d    = 3'd0;
                  state_d       = (LAST_BIT == 16'd1) ? TAIL : DATA;
               end
            end
            DATA: begin
               if (!empty) begin
                  pop         = 1'b1;
                  out_valid_d = 1'b1;
                  out_sym_d   = encode(head, shift_q);
                  shift_d     = {shift_q[4:0], head};
                  bit_cnt_d   = bit_cnt_q + 16'd1;
                  if (bit_cnt_q + 16'd1 == LAST_BIT) begin
                     state_d    = TAIL;
                     tail_cnt_d = 3'd0;
                  end
               end else begin
                  underrun_d = 1'b1;
               end
            end
            TAIL: begin
               out_valid_d = 1'b1;
               out_sym_d   = encode(1'b0, shift_q);
               shift_d     = {shift_q[4:0], 1'b0};
               tail_cnt_d  = tail_cnt_q + 3'd1;
               if (tail_cnt_q == 3'd5) begin
                  frame_end_d = 1'b1;
                  state_d     = IDLE;
                  shift_d     = '0;
                  bit_cnt_d   = '0;
                  tail_cnt_d  = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Push is blocked when full and pop when empty, so simultaneous push/pop nets to zero.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)
         count_d = count_q + (AW+1)'(1);
      else if (pop && !push)
         count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= bus.in_bit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         sync_prev_q   <= 1'b1;
         rdy_q         <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         state_q       <= IDLE;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         tail_cnt_q    <= '0;
         out_valid_q   <= 1'b0;
         out_sym_q     <= '0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         sync1_q       <= bit_clk;
         sync2_q       <= sync1_q;
         sync_prev_q   <= sync2_q;
         rdy_q         <= 1'b1;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         tail_cnt_q    <= tail_cnt_d;
         out_valid_q   <= out_valid_d;
         out_sym_q     <= out_sym_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         underrun_q    <= underrun_d;
      end
   end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed and table-driven bench for conv_encoder: three instances with
// FRAME_LEN 1, 4 and 64 cover impulse, framing, underrun, FIFO-full and reset cases.
module tb_conv_encoder;

   typedef struct packed {
      logic       fs;
      logic       fe;
      logic [1:0] sym;
   } obs_t;

   typedef struct {
      logic       has_bit;
      logic       in_bit;
      logic [1:0] sym;
      logic       fs;
      logic       fe;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic bc1, bc4, bc64;
   int   n_vec  = 0;
   int   n_miss = 0;
   obs_t q1[$], q4[$], q64[$];
   int   ur4 = 0;

   conv_encoder_if if1 ();
   conv_encoder_if if4 ();
   conv_encoder_if if64 ();

   conv_encoder #(.FRAME_LEN(1),  .FIFO_DEPTH(8)) u1  (.clk(clk), .rst(rst), .bit_clk(bc1),  .bus(if1.slave));
   conv_encoder #(.FRAME_LEN(4),  .FIFO_DEPTH(8)) u4  (.clk(clk), .rst(rst), .bit_clk(bc4),  .bus(if4.slave));
   conv_encoder #(.FRAME_LEN(64), .FIFO_DEPTH(8)) u64 (.clk(clk), .rst(rst), .bit_clk(bc64), .bus(if64.slave));

   always #5 clk = ~clk;

   // Collect every emitted symbol with its framing flags, sampled mid-cycle.
   always @(negedge clk) begin
      if (if1.out_valid)  q1.push_back(obs_t'{if1.frame_start, if1.frame_end, if1.out_sym});
      if (if4.out_valid)  q4.push_back(obs_t'{if4.frame_start, if4.frame_end, if4.out_sym});
      if (if64.out_valid) q64.push_back(obs_t'{if64.frame_start, if64.frame_end, if64.out_sym});
      if (if4.underrun)   ur4++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [1:0] refEnc(input logic u, input logic [5:0] s);
      return {u ^ s[0] ^ s[1] ^ s[2] ^ s[5], u ^ s[1] ^ s[2] ^ s[4] ^ s[5]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic setIn(input int dut, input logic v, input logic b);
      case (dut)
         1:       begin if1.in_valid  = v; if1.in_bit  = b; end
         4:       begin if4.in_valid  = v; if4.in_bit  = b; end
         default: begin if64.in_valid = v; if64.in_bit = b; end
      endcase
   endtask

   task automatic setBc(input int dut, input logic v);
      case (dut)
         1:       bc1  = v;
         4:       bc4  = v;
         default: bc64 = v;
      endcase
   endtask

   task automatic pushBit(input int dut, input logic b);
      @(negedge clk);
      setIn(dut, 1'b1, b);
      @(negedge clk);
      setIn(dut, 1'b0, 1'b0);
   endtask

   // One bit_clk period; the resulting symbol is visible by the time this returns.
   task automatic applyStimulus(input int dut);
      @(negedge clk);
      setBc(dut, 1'b1);
      repeat (3) @(negedge clk);
      setBc(dut, 1'b0);
      repeat (2) @(negedge clk);
   endtask

   vec_t       tbl [10];
   logic [1:0] imp [7];
   logic [1:0] imp4 [10];
   logic       exp_bits[$];

   initial begin
      int acc;
      int cnt_fs, cnt_fe, cnt_nz;

      tbl[0] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b1};
      imp  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
      imp4 = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};

      rst = 1'b1;
      bc1 = 1'b1;
      bc4 = 1'b0;
      bc64 = 1'b0;
      setIn(1, 1'b0, 1'b0);
      setIn(4, 1'b0, 1'b0);
      setIn(64, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("reset out_valid",   32'(if64.out_valid),   0);
      checkOutput("reset out_sym",     32'(if64.out_sym),     0);
      checkOutput("reset frame_start", 32'(if64.frame_start), 0);
      checkOutput("reset frame_end",   32'(if64.frame_end),   0);
      checkOutput("reset underrun",    32'(if64.underrun),    0);
      checkOutput("reset in_ready",    32'(if64.in_ready),    0);
      rst = 1'b0;
      #1;
      checkOutput("in_ready before first clk", 32'(if64.in_ready), 0);
      @(negedge clk);
      checkOutput("in_ready after first clk", 32'(if64.in_ready), 1);

      // bit_clk held high through reset must not tick; then the impulse on FRAME_LEN=1.
      pushBit(1, 1'b1);
      repeat (6) @(negedge clk);
      checkOutput("no spurious tick", 32'(q1.size()), 0);
      bc1 = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 7; i++) applyStimulus(1);
      checkOutput("impulse count", 32'(q1.size()), 7);
      for (int i = 0; i < 7; i++) begin
         checkOutput($sformatf("impulse sym %0d", i), 32'(q1[i].sym), 32'(imp[i]));
         checkOutput($sformatf("impulse fs %0d", i),  32'(q1[i].fs),  (i == 0) ? 1 : 0);
         checkOutput($sformatf("impulse fe %0d", i),  32'(q1[i].fe),  (i == 6) ? 1 : 0);
      end

      q4.delete();
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].has_bit) pushBit(4, tbl[i].in_bit);
         applyStimulus(4);
         checkOutput($sformatf("table count %0d", i), 32'(q4.size()), 32'(i + 1));
         checkOutput($sformatf("table sym %0d", i), 32'(q4[i].sym), 32'(tbl[i].sym));
         checkOutput($sformatf("table fs %0d", i),  32'(q4[i].fs),  32'(tbl[i].fs));
         checkOutput($sformatf("table fe %0d", i),  32'(q4[i].fe),  32'(tbl[i].fe));
      end

      // Underrun mid-frame: the frame stalls and resumes with the same symbols.
      q4.delete();
      ur4 = 0;
      pushBit(4, 1'b1);
      pushBit(4, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(4);
      checkOutput("underrun symbols", 32'(q4.size()), 2);
      checkOutput("underrun pulses", 32'(ur4), 1);
      pushBit(4, 1'b0);
      pushBit(4, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(4);
      checkOutput("resume symbols", 32'(q4.size()), 10);
      checkOutput("resume underruns", 32'(ur4), 1);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("resume sym %0d", i), 32'(q4[i].sym), 32'(tbl[i].sym));
         checkOutput($sformatf("resume fe %0d", i),  32'(q4[i].fe),  32'(tbl[i].fe));
      end

      q64.delete();
      for (int i = 0; i < 70; i++) begin
         if (i < 64) pushBit(64, 1'b0);
         applyStimulus(64);
      end
      cnt_fs = 0; cnt_fe = 0; cnt_nz = 0;
      foreach (q64[i]) begin
         if (q64[i].fs) cnt_fs++;
         if (q64[i].fe) cnt_fe++;
         if (q64[i].sym != 2'b00) cnt_nz++;
      end
      checkOutput("zero symbols", 32'(q64.size()), 70);
      checkOutput("zero nonzero syms", 32'(cnt_nz), 0);
      checkOutput("zero frame_start count", 32'(cnt_fs), 1);
      checkOutput("zero frame_end count", 32'(cnt_fe), 1);
      checkOutput("zero first fs", 32'(q64[0].fs), 1);
      checkOutput("zero last fe", 32'(q64[69].fe), 1);

      // FIFO fill with no ticks, then a push coinciding with a pop at occupancy 7.
      acc = 0;
      @(negedge clk);
      setIn(64, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         if (if64.in_ready) acc++;
         @(negedge clk);
      end
      setIn(64, 1'b0, 1'b0);
      checkOutput("fifo accepted", 32'(acc), 8);
      checkOutput("fifo full in_ready", 32'(if64.in_ready), 0);
      applyStimulus(64);
      checkOutput("fifo after pop in_ready", 32'(if64.in_ready), 1);
      bc64 = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("fifo ready at push+pop", 32'(if64.in_ready), 1);
      setIn(64, 1'b1, 1'b0);
      @(negedge clk);
      setIn(64, 1'b0, 1'b0);
      bc64 = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("fifo occupancy kept", 32'(if64.in_ready), 1);
      pushBit(64, 1'b0);
      checkOutput("fifo refilled in_ready", 32'(if64.in_ready), 0);

      // Reset while a frame_start symbol is on the outputs.
      pushBit(4, 1'b1);
      pushBit(4, 1'b1);
      @(negedge clk);
      bc4 = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("pre-reset out_valid", 32'(if4.out_valid), 1);
      checkOutput("pre-reset frame_start", 32'(if4.frame_start), 1);
      rst = 1'b1;
      #1;
      checkOutput("mid reset out_valid", 32'(if4.out_valid), 0);
      checkOutput("mid reset out_sym", 32'(if4.out_sym), 0);
      checkOutput("mid reset frame_start", 32'(if4.frame_start), 0);
      checkOutput("mid reset in_ready", 32'(if4.in_ready), 0);
      bc4 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      q4.delete();
      for (int i = 0; i < 10; i++) begin
         if (i < 4) pushBit(4, (i == 0) ? 1'b1 : 1'b0);
         applyStimulus(4);
      end
      checkOutput("post-reset count", 32'(q4.size()), 10);
      for (int i = 0; i < 10; i++)
         checkOutput($sformatf("post-reset sym %0d", i), 32'(q4[i].sym), 32'(imp4[i]));
      checkOutput("post-reset fe", 32'(q4[9].fe), 1);

      // Random valid and tick spacing over three FRAME_LEN=4 frames.
      q4.delete();
      exp_bits.delete();
      fork
         begin
            int n = 0;
            int cyc = 0;
            while (n < 12 && cyc < 4000) begin
               logic v, b;
               @(negedge clk);
               v = 1'($urandom_range(0, 1));
               b = 1'($urandom_range(0, 1));
               if (v && if4.in_ready) begin
                  exp_bits.push_back(b);
                  n++;
               end
               setIn(4, v, b);
               cyc++;
            end
            @(negedge clk);
            setIn(4, 1'b0, 1'b0);
         end
         begin
            int tk = 0;
            while (q4.size() < 30 && tk < 300) begin
               @(negedge clk);
               bc4 = 1'b1;
               repeat ($urandom_range(2, 4)) @(negedge clk);
               bc4 = 1'b0;
               repeat ($urandom_range(2, 4)) @(negedge clk);
               tk++;
            end
         end
      join
      checkOutput("random pushes", 32'(exp_bits.size()), 12);
      checkOutput("random symbols", 32'(q4.size()), 30);
      begin
         logic [5:0] s;
         int bi;
         s = '0;
         bi = 0;
         for (int k = 0; k < 30; k++) begin
            int pos;
            logic u;
            pos = k % 10;
            u = 1'b0;
            if (pos < 4) begin
               u = exp_bits[bi];
               bi++;
            end
            checkOutput($sformatf("random sym %0d", k), 32'(q4[k].sym), 32'(refEnc(u, s)));
            checkOutput($sformatf("random fs %0d", k),  32'(q4[k].fs),  (pos == 0) ? 1 : 0);
            checkOutput($sformatf("random fe %0d", k),  32'(q4[k].fe),  (pos == 9) ? 1 : 0);
            s = (pos == 9) ? 6'd0 : {s[4:0], u};
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
